// File: rtl/dds_param_sequencer.sv
// Front-panel key sequencer for the DDS core: sync, debounce, step one parameter, then hand it off.
// Optional macro AUTO_REPEAT_EN adds auto-repeat stepping while f/a/p keys are held.
module dds_param_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int F_INIT          = 8590,
    parameter int F_STEP          = 42950,
    parameter int F_MAX           = 1717987,
    parameter int P_STEP          = 100,
    parameter int A_MAX           = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_wave_n,
    input  logic        key_f_n,
    input  logic        key_a_n,
    input  logic        key_p_n,
    input  logic        upd_ready,
    output logic [1:0]  set_waveform,
    output logic [20:0] f_control,
    output logic [3:0]  a_control,
    output logic [8:0]  p_control,
    output logic        upd_valid,
    output logic [1:0]  upd_src
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DEBOUNCE, APPLY, HANDSHAKE, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       wave_q, wave_d;
    logic [20:0]      f_q, f_d;
    logic [3:0]       a_q, a_d;
    logic [8:0]       p_q, p_d;
    logic [1:0]       src_q, src_d;
    logic             key_low;
    logic [21:0]      f_sum;
    logic [9:0]       p_sum;
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_q, rep_d;
`endif

    // Bit order of every key vector: 0 = wave, 1 = f, 2 = a, 3 = p (also the upd_src code).
    assign key_low = ~sync2_q[sel_q];
    assign f_sum   = {1'b0, f_q} + 22'(F_STEP);
    assign p_sum   = {1'b0, p_q} + 10'(P_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            wave_q  <= 2'd0;
            f_q     <= 21'(F_INIT);
            a_q     <= 4'd1;
            p_q     <= 9'd0;
            src_q   <= 2'd0;
`ifdef AUTO_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            wave_q  <= wave_d;
            f_q     <= f_d;
            a_q     <= a_d;
            p_q     <= p_d;
            src_q   <= src_d;
`ifdef AUTO_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sync1_d = {key_p_n, key_a_n, key_f_n, key_wave_n};
        sync2_d = sync1_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        wave_d  = wave_q;
        f_d     = f_q;
        a_d     = a_q;
        p_d     = p_q;
        src_d   = src_q;
`ifdef AUTO_REPEAT_EN
        rep_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (!(&sync2_q)) begin
                    if (!sync2_q[0])      sel_d = 2'd0;
                    else if (!sync2_q[1]) sel_d = 2'd1;
                    else if (!sync2_q[2]) sel_d = 2'd2;
                    else                  sel_d = 2'd3;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_low)              state_d = IDLE;
                else if (cnt_q == DEB_LAST) state_d = APPLY;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            APPLY: begin
                src_d = sel_q;
                case (sel_q)
                    2'd0: wave_d = wave_q + 2'd1;
                    2'd1: f_d    = (f_sum > 22'(F_MAX)) ? 21'(F_INIT) : f_sum[20:0];
                    2'd2: a_d    = (a_q == 4'(A_MAX)) ? 4'd1 : a_q + 4'd1;
                    default: p_d = (p_sum > 10'd511) ? 9'd0 : p_sum[8:0];
                endcase
                state_d = HANDSHAKE;
            end
            HANDSHAKE: begin
                cnt_d = '0;
                if (upd_ready) state_d = RELEASE;
            end
            RELEASE: begin
                // A low sample restarts the release count; with auto-repeat it also advances the repeat timer.
                if (key_low) begin
                    cnt_d = '0;
`ifdef AUTO_REPEAT_EN
                    if (sel_q != 2'd0) begin
                        if (rep_q == REP_LAST) state_d = APPLY;
                        else                   rep_d   = rep_q + 1'b1;
                    end
`endif
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        set_waveform = wave_q;
        f_control    = f_q;
        a_control    = a_q;
        p_control    = p_q;
        upd_src      = src_q;
        upd_valid    = (state_q == HANDSHAKE);
    end

endmodule

// File: tb/tb_dds_param_sequencer.sv
// Directed bench for dds_param_sequencer with short debounce/repeat timing.
// Build with AUTO_REPEAT_EN defined to check the auto-repeat variant.
module tb_dds_param_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  keys_n;
    logic        upd_ready;
    logic [1:0]  set_waveform;
    logic [20:0] f_control;
    logic [3:0]  a_control;
    logic [8:0]  p_control;
    logic        upd_valid;
    logic [1:0]  upd_src;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    dds_param_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_wave_n  (keys_n[0]),
        .key_f_n     (keys_n[1]),
        .key_a_n     (keys_n[2]),
        .key_p_n     (keys_n[3]),
        .upd_ready   (upd_ready),
        .set_waveform(set_waveform),
        .f_control   (f_control),
        .a_control   (a_control),
        .p_control   (p_control),
        .upd_valid   (upd_valid),
        .upd_src     (upd_src)
    );

    always #5 clk = ~clk;

    // Count accepted updates (valid and ready on the same edge).
    always @(posedge clk) begin
        if (!reset && upd_valid && upd_ready) pulses <= pulses + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx, input int low_n);
        keys_n[idx] = 1'b0;
        cycles(low_n);
        keys_n[idx] = 1'b1;
        cycles(12);
    endtask

    task automatic wait_valid(input int limit, input string name);
        int k;
        k = 0;
        while (!upd_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (upd_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: upd_valid=%b after %0d cycles, required 1", name, upd_valid, limit);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(2);
        checks += 6;
        if (set_waveform !== 2'd0) begin errors++; $display("[TB] FAIL reset_wave: got %0d want 0", set_waveform); end
        if (f_control !== 21'd8590) begin errors++; $display("[TB] FAIL reset_f: got %0d want 8590", f_control); end
        if (a_control !== 4'd1) begin errors++; $display("[TB] FAIL reset_a: got %0d want 1", a_control); end
        if (p_control !== 9'd0) begin errors++; $display("[TB] FAIL reset_p: got %0d want 0", p_control); end
        if (upd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", upd_valid); end
        if (upd_src !== 2'd0) begin errors++; $display("[TB] FAIL reset_src: got %0d want 0", upd_src); end
        reset = 1'b0;
        cycles(2);
    endtask

    task automatic test_glitch();
        int start;
        start = pulses;
        press(1, 3);
        cycles(5);
        checks += 2;
        if (f_control !== 21'd8590) begin errors++; $display("[TB] FAIL glitch_f: got %0d want 8590", f_control); end
        if (pulses - start !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d want 0", pulses - start); end
    endtask

    task automatic test_single_press();
        int start;
        start = pulses;
        press(1, 10);
        checks += 3;
        if (f_control !== 21'd51540) begin errors++; $display("[TB] FAIL single_f: got %0d want 51540", f_control); end
        if (upd_src !== 2'd1) begin errors++; $display("[TB] FAIL single_src: got %0d want 1", upd_src); end
        if (pulses - start !== 1) begin errors++; $display("[TB] FAIL single_pulses: got %0d want 1", pulses - start); end
    endtask

    // Press 1 already happened; presses 2..40 finish the sweep.
    task automatic test_freq_wrap();
        int start;
        start = pulses;
        for (int i = 2; i <= 40; i++) begin
            press(1, 10);
            if (i == 39) begin
                checks++;
                if (f_control !== 21'd1683640) begin errors++; $display("[TB] FAIL freq_39: got %0d want 1683640", f_control); end
            end
            if (i == 40) begin
                checks++;
                if (f_control !== 21'd8590) begin errors++; $display("[TB] FAIL freq_40: got %0d want 8590", f_control); end
            end
        end
        checks++;
        if (pulses - start !== 39) begin errors++; $display("[TB] FAIL freq_pulses: got %0d want 39", pulses - start); end
    endtask

    task automatic test_amp_wrap();
        for (int i = 1; i <= 10; i++) begin
            press(2, 10);
            if (i == 9) begin
                checks++;
                if (a_control !== 4'd10) begin errors++; $display("[TB] FAIL amp_9: got %0d want 10", a_control); end
            end
        end
        checks += 2;
        if (a_control !== 4'd1) begin errors++; $display("[TB] FAIL amp_10: got %0d want 1", a_control); end
        if (upd_src !== 2'd2) begin errors++; $display("[TB] FAIL amp_src: got %0d want 2", upd_src); end
    endtask

    task automatic test_phase_wrap();
        for (int i = 1; i <= 6; i++) begin
            press(3, 10);
            if (i == 5) begin
                checks++;
                if (p_control !== 9'd500) begin errors++; $display("[TB] FAIL phase_5: got %0d want 500", p_control); end
            end
        end
        checks += 2;
        if (p_control !== 9'd0) begin errors++; $display("[TB] FAIL phase_6: got %0d want 0", p_control); end
        if (upd_src !== 2'd3) begin errors++; $display("[TB] FAIL phase_src: got %0d want 3", upd_src); end
    endtask

    task automatic test_simultaneous();
        keys_n[0] = 1'b0;
        keys_n[1] = 1'b0;
        wait_valid(20, "simul_wave_valid");
        checks += 3;
        if (set_waveform !== 2'd1) begin errors++; $display("[TB] FAIL simul_wave: got %0d want 1", set_waveform); end
        if (f_control !== 21'd8590) begin errors++; $display("[TB] FAIL simul_f_held: got %0d want 8590", f_control); end
        if (upd_src !== 2'd0) begin errors++; $display("[TB] FAIL simul_src0: got %0d want 0", upd_src); end
        cycles(2);
        keys_n[0] = 1'b1;
        wait_valid(30, "simul_f_valid");
        checks += 3;
        if (f_control !== 21'd51540) begin errors++; $display("[TB] FAIL simul_f: got %0d want 51540", f_control); end
        if (upd_src !== 2'd1) begin errors++; $display("[TB] FAIL simul_src1: got %0d want 1", upd_src); end
        if (set_waveform !== 2'd1) begin errors++; $display("[TB] FAIL simul_wave_kept: got %0d want 1", set_waveform); end
        keys_n[1] = 1'b1;
        cycles(15);
    endtask

    task automatic test_backpressure();
        upd_ready = 1'b0;
        press(1, 10);
        checks += 3;
        if (upd_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b want 1", upd_valid); end
        if (f_control !== 21'd94490) begin errors++; $display("[TB] FAIL bp_f: got %0d want 94490", f_control); end
        if (upd_src !== 2'd1) begin errors++; $display("[TB] FAIL bp_src: got %0d want 1", upd_src); end
        press(2, 10);
        checks += 3;
        if (upd_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_held: got %b want 1", upd_valid); end
        if (a_control !== 4'd1) begin errors++; $display("[TB] FAIL bp_a_ignored: got %0d want 1", a_control); end
        if (f_control !== 21'd94490) begin errors++; $display("[TB] FAIL bp_f_frozen: got %0d want 94490", f_control); end
        reset = 1'b1;
        cycles(1);
        checks += 6;
        if (upd_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_rst_valid: got %b want 0", upd_valid); end
        if (f_control !== 21'd8590) begin errors++; $display("[TB] FAIL bp_rst_f: got %0d want 8590", f_control); end
        if (set_waveform !== 2'd0) begin errors++; $display("[TB] FAIL bp_rst_wave: got %0d want 0", set_waveform); end
        if (a_control !== 4'd1) begin errors++; $display("[TB] FAIL bp_rst_a: got %0d want 1", a_control); end
        if (p_control !== 9'd0) begin errors++; $display("[TB] FAIL bp_rst_p: got %0d want 0", p_control); end
        if (upd_src !== 2'd0) begin errors++; $display("[TB] FAIL bp_rst_src: got %0d want 0", upd_src); end
        reset = 1'b0;
        upd_ready = 1'b1;
        cycles(3);
    endtask

    task automatic test_auto_repeat();
        int start;
        int delta;
        start = pulses;
        keys_n[3] = 1'b0;
        cycles(40);
        keys_n[3] = 1'b1;
        cycles(15);
        delta = pulses - start;
        checks += 2;
`ifdef AUTO_REPEAT_EN
        if (delta < 2) begin errors++; $display("[TB] FAIL repeat_pulses: got %0d want at least 2", delta); end
        if (p_control !== 9'(100 * delta)) begin errors++; $display("[TB] FAIL repeat_p: got %0d want %0d", p_control, 100 * delta); end
`else
        if (delta !== 1) begin errors++; $display("[TB] FAIL repeat_pulses: got %0d want 1", delta); end
        if (p_control !== 9'd100) begin errors++; $display("[TB] FAIL repeat_p: got %0d want 100", p_control); end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        keys_n    = 4'hF;
        upd_ready = 1'b1;
        cycles(1);
        test_reset();
        test_glitch();
        test_single_press();
        test_freq_wrap();
        test_amp_wrap();
        test_phase_wrap();
        test_simultaneous();
        test_backpressure();
        test_auto_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
